// File: rtl/core_run_controller.sv
`timescale 1ns/1ps
// Boot/run sequencer: streams a program into the core's instruction memory,
// releases core reset, runs for a programmed cycle count, then reports done.
module core_run_controller #(
   parameter int INSTRUCTION_LEN = 32,
   parameter int IMEM_ADDR_SIZE  = 10,
   parameter int CYCLE_CNT_LEN   = 16,
   parameter int FLUSH_CYCLES    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       load_valid,
   input  logic [INSTRUCTION_LEN-1:0] load_data,
   input  logic                       load_last,
   output logic                       load_ready,
   input  logic [CYCLE_CNT_LEN-1:0]   run_cycles,
   output logic                       ins_write,
   output logic [INSTRUCTION_LEN-1:0] instruction_out,
   output logic                       core_rst,
   output logic                       busy,
   output logic                       done,
   output logic [IMEM_ADDR_SIZE:0]    word_count,
   output logic                       overflow
);

   typedef enum logic [2:0] {
      S_IDLE, S_RSTP, S_LOAD, S_FLUSH, S_RUN, S_DONE
   } state_t;

   localparam int                  FLUSH_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FLUSH_W-1:0]  FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
   localparam logic [IMEM_ADDR_SIZE:0] CAPACITY = {1'b1, {IMEM_ADDR_SIZE{1'b0}}};

   state_t                     state, state_nx;
   logic [FLUSH_W-1:0]         flush_cnt, flush_nx;
   logic [CYCLE_CNT_LEN-1:0]   run_cnt, run_nx;
   logic                       free_run, free_nx;
   logic [IMEM_ADDR_SIZE:0]    wc_nx;
   logic                       ovf_nx;
   logic                       wr_nx;
   logic [INSTRUCTION_LEN-1:0] data_nx;
   logic                       ready_nx, core_rst_nx, busy_nx, done_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         flush_cnt       <= '0;
         run_cnt         <= '0;
         free_run        <= 1'b0;
         word_count      <= '0;
         overflow        <= 1'b0;
         ins_write       <= 1'b0;
         instruction_out <= '0;
         load_ready      <= 1'b0;
         core_rst        <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         state           <= state_nx;
         flush_cnt       <= flush_nx;
         run_cnt         <= run_nx;
         free_run        <= free_nx;
         word_count      <= wc_nx;
         overflow        <= ovf_nx;
         ins_write       <= wr_nx;
         instruction_out <= data_nx;
         load_ready      <= ready_nx;
         core_rst        <= core_rst_nx;
         busy            <= busy_nx;
         done            <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      flush_nx = flush_cnt;
      run_nx   = run_cnt;
      free_nx  = free_run;
      wc_nx    = word_count;
      ovf_nx   = overflow;
      wr_nx    = 1'b0;
      data_nx  = instruction_out;

      if (abort) begin
         state_nx = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state_nx = S_RSTP;
                  wc_nx    = '0;
                  ovf_nx   = 1'b0;
               end
            end
            S_RSTP: state_nx = S_LOAD;
            S_LOAD: begin
               if (load_valid && load_ready) begin
                  wr_nx   = 1'b1;
                  data_nx = load_data;
                  wc_nx   = word_count + 1'b1;
                  if (load_last) begin
                     run_nx   = run_cycles;
                     free_nx  = (run_cycles == '0);
                     flush_nx = '0;
                     state_nx = S_FLUSH;
                  end
               end else if (load_valid && word_count == CAPACITY) begin
                  // Program longer than memory: abandon the load without writing.
                  ovf_nx   = 1'b1;
                  state_nx = S_DONE;
               end
            end
            S_FLUSH: begin
               if (flush_cnt == FLUSH_LAST) state_nx = S_RUN;
               else                         flush_nx = flush_cnt + 1'b1;
            end
            S_RUN: begin
               if (!free_run) begin
                  if (run_cnt == CYCLE_CNT_LEN'(1)) state_nx = S_DONE;
                  else                               run_nx   = run_cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (start) begin
                  state_nx = S_RSTP;
                  wc_nx    = '0;
                  ovf_nx   = 1'b0;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end

      // Outputs are decoded from the next state so the registered copies track the state.
      core_rst_nx = state_nx inside {S_LOAD, S_FLUSH, S_RUN, S_DONE};
      busy_nx     = state_nx inside {S_RSTP, S_LOAD, S_FLUSH, S_RUN};
      done_nx     = (state_nx == S_DONE);
      ready_nx    = (state_nx == S_LOAD) && (wc_nx < CAPACITY);
   end

endmodule

// File: tb/tb_core_run_controller.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for core_run_controller: expected instruction
// writes are queued at acceptance and retired by an independent write monitor.
module tb_core_run_controller;

   localparam int IW  = 32;
   localparam int AS  = 2;
   localparam int CL  = 16;
   localparam int FL  = 4;
   localparam int CAP = 1 << AS;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          load_valid = 1'b0;
   logic [IW-1:0] load_data = '0;
   logic          load_last = 1'b0;
   logic          load_ready;
   logic [CL-1:0] run_cycles = '0;
   logic          ins_write;
   logic [IW-1:0] instruction_out;
   logic          core_rst;
   logic          busy;
   logic          done;
   logic [AS:0]   word_count;
   logic          overflow;

   typedef struct {
      logic [IW-1:0] data;
      int unsigned   cyc;
   } wr_t;

   wr_t           sb[$];
   logic [IW-1:0] fixed[$];
   int unsigned   cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   core_run_controller #(
      .INSTRUCTION_LEN(IW),
      .IMEM_ADDR_SIZE(AS),
      .CYCLE_CNT_LEN(CL),
      .FLUSH_CYCLES(FL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_last(load_last),
      .load_ready(load_ready),
      .run_cycles(run_cycles),
      .ins_write(ins_write),
      .instruction_out(instruction_out),
      .core_rst(core_rst),
      .busy(busy),
      .done(done),
      .word_count(word_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Write monitor: every ins_write pulse must match the oldest accepted beat, one cycle later.
   always @(negedge clk) begin
      if (rst && ins_write) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write actual=%0h required=none", instruction_out);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("write_data", instruction_out, e.data);
            chk("write_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic begin_session(input int ncyc);
      @(negedge clk);
      start = 1'b1;
      run_cycles = CL'(ncyc);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("rstp_busy", busy, 1);
      chk("rstp_core_rst", core_rst, 0);
      chk("rstp_word_count", word_count, 0);
      chk("rstp_overflow", overflow, 0);
      chk("rstp_ready", load_ready, 0);
      @(posedge clk);
   endtask

   // mode: 0 back-to-back, 1 alternating valid, 2 random valid with stray start
   // endm: 0 expect done, 1 free-run then abort, 2 free-run then async reset
   task automatic session(input int last_at, input int mode, input int ncyc, input int endm);
      int            wc;
      int            beat;
      int            k;
      int            quiet;
      bit            fin;
      bit            v;
      logic [IW-1:0] last_data;
      wc = 0; beat = 1; fin = 0; last_data = '0;
      begin_session(ncyc);
      for (int t = 0; t < 200 && !fin; t++) begin
         @(negedge clk);
         chk("load_ready", load_ready, wc < CAP);
         chk("load_word_count", word_count, wc);
         if (wc == CAP) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            load_last  = (beat == last_at);
            start      = 1'b0;
            @(posedge clk);
            @(negedge clk);
            load_valid = 1'b0;
            load_last  = 1'b0;
            chk("ovf_flag", overflow, 1);
            chk("ovf_done", done, 1);
            chk("ovf_busy", busy, 0);
            chk("ovf_word_count", word_count, CAP);
            return;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = (t % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         if (mode == 2) start = 1'($urandom_range(0, 1));
         load_valid = v;
         if (v && fixed.size() > 0) load_data = fixed.pop_front();
         else                       load_data = $urandom;
         load_last = v && (beat == last_at);
         if (v) begin
            sb.push_back('{load_data, cyc + 1});
            last_data = load_data;
            wc++;
            if (beat == last_at) fin = 1'b1;
            beat++;
         end
         @(posedge clk);
      end
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      start      = 1'b0;
      load_data  = $urandom;
      chk("flush_word_count", word_count, wc);
      chk("flush_core_rst", core_rst, 1);
      chk("flush_ready", load_ready, 0);
      chk("flush_busy", busy, 1);
      k = 0;
      if (endm == 0) begin
         while (!done && k < FL + ncyc + 20) begin
            @(negedge clk);
            k++;
         end
         chk("done_latency", k, FL + ncyc);
         chk("done_busy", busy, 0);
         chk("done_core_rst", core_rst, 1);
         chk("done_hold_data", instruction_out, last_data);
         chk("done_word_count", word_count, wc);
         chk("done_overflow", overflow, 0);
      end else begin
         quiet = 0;
         repeat (1000) begin
            @(negedge clk);
            if (!done && busy && core_rst) quiet++;
         end
         chk("freerun_cycles", quiet, 1000);
         if (endm == 1) begin
            abort = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_core_rst", core_rst, 0);
            chk("abort_word_count", word_count, wc);
         end else begin
            #2 rst = 1'b0;
            #1;
            chk("rst_core_rst", core_rst, 0);
            chk("rst_ins_write", ins_write, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_word_count", word_count, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_ready", load_ready, 0);
            @(negedge clk);
            rst = 1'b1;
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_core_rst", core_rst, 0);
      chk("reset_ins_write", ins_write, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_word_count", word_count, 0);
      chk("reset_overflow", overflow, 0);
      chk("reset_ready", load_ready, 0);
      rst = 1'b1;

      fixed.push_back(32'h00500093);
      fixed.push_back(32'h00A00113);
      fixed.push_back(32'h002081B3);
      session(3, 0, 20, 0);
      session(3, 1, 5, 0);
      session(5, 0, 7, 0);
      session(4, 0, 3, 0);

      begin_session(5);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = $urandom;
         sb.push_back('{load_data, cyc + 1});
         @(posedge clk);
      end
      @(negedge clk);
      load_valid = 1'b0;
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_load_busy", busy, 0);
      chk("abort_load_core_rst", core_rst, 0);
      chk("abort_load_word_count", word_count, 2);

      session(2, 2, 0, 1);

      session(2, 0, 9, 0);
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      chk("start_abort_done", done, 0);
      chk("start_abort_core_rst", core_rst, 0);

      for (int s = 0; s < 6; s++)
         session($urandom_range(1, CAP), 2, $urandom_range(1, 30), 0);

      session(2, 0, 0, 2);

      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
